tl_mem_arb: RTL and testbench

Two-requester TileLink-UL arbiter in front of `tl_mem`. Two upstream masters (e.g. instruction fetch and data side) each drive a full A/D channel pair into this block. The block grants `tl_mem` to one requester per transaction, locks the grant from the first A beat through the last D beat, and routes every D beat back to the owner. Only one transaction is outstanding at `tl_mem` at any time. Beat size is 128 bits (16 bytes).

---
 rtl/tl_mem_arb.sv | 200 ++++++++++++++++++++
 tb/tb_tl_mem_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_mem_arb.sv
// Two-requester TileLink-UL arbiter in front of tl_mem: one transaction outstanding,
// grant locked from first A beat to last D beat, D beats routed back to the owner.
module tl_mem_arb #(
  parameter int RR_EN = 1
) (
  input  logic         clk,
  input  logic         rst,

  input  logic [2:0]   tlslv0_a_opcode,
  input  logic [2:0]   tlslv0_a_param,
  input  logic [7:0]   tlslv0_a_size,
  input  logic [2:0]   tlslv0_a_source,
  input  logic [31:0]  tlslv0_a_address,
  input  logic [15:0]  tlslv0_a_mask,
  input  logic [127:0] tlslv0_a_data,
  input  logic         tlslv0_a_corrupt,
  input  logic         tlslv0_a_valid,
  output logic         tlslv0_a_ready,
  output logic [2:0]   tlslv0_d_opcode,
  output logic [1:0]   tlslv0_d_param,
  output logic [7:0]   tlslv0_d_size,
  output logic [2:0]   tlslv0_d_source,
  output logic [2:0]   tlslv0_d_sink,
  output logic         tlslv0_d_denied,
  output logic [127:0] tlslv0_d_data,
  output logic         tlslv0_d_corrupt,
  output logic         tlslv0_d_valid,
  input  logic         tlslv0_d_ready,

  input  logic [2:0]   tlslv1_a_opcode,
  input  logic [2:0]   tlslv1_a_param,
  input  logic [7:0]   tlslv1_a_size,
  input  logic [2:0]   tlslv1_a_source,
  input  logic [31:0]  tlslv1_a_address,
  input  logic [15:0]  tlslv1_a_mask,
  input  logic [127:0] tlslv1_a_data,
  input  logic         tlslv1_a_corrupt,
  input  logic         tlslv1_a_valid,
  output logic         tlslv1_a_ready,
  output logic [2:0]   tlslv1_d_opcode,
  output logic [1:0]   tlslv1_d_param,
  output logic [7:0]   tlslv1_d_size,
  output logic [2:0]   tlslv1_d_source,
  output logic [2:0]   tlslv1_d_sink,
  output logic         tlslv1_d_denied,
  output logic [127:0] tlslv1_d_data,
  output logic         tlslv1_d_corrupt,
  output logic         tlslv1_d_valid,
  input  logic         tlslv1_d_ready,

  output logic [2:0]   tlmst_a_opcode,
  output logic [2:0]   tlmst_a_param,
  output logic [7:0]   tlmst_a_size,
  output logic [2:0]   tlmst_a_source,
  output logic [31:0]  tlmst_a_address,
  output logic [15:0]  tlmst_a_mask,
  output logic [127:0] tlmst_a_data,
  output logic         tlmst_a_corrupt,
  output logic         tlmst_a_valid,
  input  logic         tlmst_a_ready,
  input  logic [2:0]   tlmst_d_opcode,
  input  logic [1:0]   tlmst_d_param,
  input  logic [7:0]   tlmst_d_size,
  input  logic [2:0]   tlmst_d_source,
  input  logic [2:0]   tlmst_d_sink,
  input  logic         tlmst_d_denied,
  input  logic [127:0] tlmst_d_data,
  input  logic         tlmst_d_corrupt,
  input  logic         tlmst_d_valid,
  output logic         tlmst_d_ready
);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  typedef enum logic [1:0] {IDLE, A_BURST, WAIT_D} state_t;

  state_t     state;
  logic       owner;
  logic       rr;
  logic [7:0] a_left;
  logic [7:0] d_left;

  logic       gnt;
  logic       sel;
  logic       a_en;
  logic       d_en;
  logic       a_hs;
  logic       d_hs;
  logic [7:0] first_a_beats;
  logic [7:0] first_d_beats;

  function automatic logic [7:0] beats(input logic [7:0] size);
    logic [7:0] b;
    if (size <= 8'd4) b = 8'd1;
    else              b = 8'd1 << (size - 8'd4);
    return b;
  endfunction

  always_comb begin
    gnt = 1'b0;
    if (tlslv0_a_valid && tlslv1_a_valid) gnt = (RR_EN != 0) ? !rr : 1'b0;
    else if (tlslv1_a_valid)              gnt = 1'b1;
    sel  = (state == IDLE) ? gnt : owner;
    // A is closed while waiting for D so tl_mem never sees a second transaction.
    a_en = !rst && (state != WAIT_D);
    d_en = !rst && (state != IDLE);
  end

  always_comb begin
    if (sel) begin
      tlmst_a_opcode  = tlslv1_a_opcode;
      tlmst_a_param   = tlslv1_a_param;
      tlmst_a_size    = tlslv1_a_size;
      tlmst_a_source  = tlslv1_a_source;
      tlmst_a_address = tlslv1_a_address;
      tlmst_a_mask    = tlslv1_a_mask;
      tlmst_a_data    = tlslv1_a_data;
      tlmst_a_corrupt = tlslv1_a_corrupt;
    end else begin
      tlmst_a_opcode  = tlslv0_a_opcode;
      tlmst_a_param   = tlslv0_a_param;
      tlmst_a_size    = tlslv0_a_size;
      tlmst_a_source  = tlslv0_a_source;
      tlmst_a_address = tlslv0_a_address;
      tlmst_a_mask    = tlslv0_a_mask;
      tlmst_a_data    = tlslv0_a_data;
      tlmst_a_corrupt = tlslv0_a_corrupt;
    end
    tlmst_a_valid  = a_en && (sel ? tlslv1_a_valid : tlslv0_a_valid);
    tlslv0_a_ready = a_en && !sel && tlmst_a_ready;
    tlslv1_a_ready = a_en &&  sel && tlmst_a_ready;
    tlmst_d_ready  = d_en && (owner ? tlslv1_d_ready : tlslv0_d_ready);
    tlslv0_d_valid = d_en && !owner && tlmst_d_valid;
    tlslv1_d_valid = d_en &&  owner && tlmst_d_valid;
    a_hs = tlmst_a_valid && tlmst_a_ready;
    d_hs = tlmst_d_valid && tlmst_d_ready;
    if (tlmst_a_opcode == OP_PUT_FULL || tlmst_a_opcode == OP_PUT_PART)
      first_a_beats = beats(tlmst_a_size);
    else
      first_a_beats = 8'd1;
    first_d_beats = (tlmst_a_opcode == OP_GET) ? beats(tlmst_a_size) : 8'd1;
  end

  // D payload is broadcast; only the owner ever sees d_valid.
  assign tlslv0_d_opcode  = tlmst_d_opcode;
  assign tlslv0_d_param   = tlmst_d_param;
  assign tlslv0_d_size    = tlmst_d_size;
  assign tlslv0_d_source  = tlmst_d_source;
  assign tlslv0_d_sink    = tlmst_d_sink;
  assign tlslv0_d_denied  = tlmst_d_denied;
  assign tlslv0_d_data    = tlmst_d_data;
  assign tlslv0_d_corrupt = tlmst_d_corrupt;
  assign tlslv1_d_opcode  = tlmst_d_opcode;
  assign tlslv1_d_param   = tlmst_d_param;
  assign tlslv1_d_size    = tlmst_d_size;
  assign tlslv1_d_source  = tlmst_d_source;
  assign tlslv1_d_sink    = tlmst_d_sink;
  assign tlslv1_d_denied  = tlmst_d_denied;
  assign tlslv1_d_data    = tlmst_d_data;
  assign tlslv1_d_corrupt = tlmst_d_corrupt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      rr     <= 1'b1;
      a_left <= '0;
      d_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_hs) begin
            owner  <= gnt;
            rr     <= gnt;
            a_left <= first_a_beats - 8'd1;
            d_left <= first_d_beats;
            state  <= (first_a_beats > 8'd1) ? A_BURST : WAIT_D;
          end
        end
        A_BURST: begin
          if (a_hs) begin
            a_left <= a_left - 8'd1;
            if (a_left == 8'd1) state <= WAIT_D;
          end
          if (d_hs) d_left <= d_left - 8'd1;
        end
        WAIT_D: begin
          if (d_hs) begin
            d_left <= d_left - 8'd1;
            if (d_left <= 8'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_mem_arb.sv
// Directed bench for tl_mem_arb: a small tl_mem responder model plus per-scenario tasks.
// A second instance with fixed priority is exercised by the last scenario.
module tb_tl_mem_arb;

  logic clk, rst;
  int tests, fails;

  logic [2:0] tlslv0_a_opcode, tlslv0_a_param, tlslv0_a_source;
  logic [7:0] tlslv0_a_size; logic [31:0] tlslv0_a_address; logic [15:0] tlslv0_a_mask;
  logic [127:0] tlslv0_a_data; logic tlslv0_a_corrupt, tlslv0_a_valid, tlslv0_a_ready;
  logic [2:0] tlslv0_d_opcode, tlslv0_d_source, tlslv0_d_sink; logic [1:0] tlslv0_d_param;
  logic [7:0] tlslv0_d_size; logic tlslv0_d_denied, tlslv0_d_corrupt, tlslv0_d_valid, tlslv0_d_ready;
  logic [127:0] tlslv0_d_data;

  logic [2:0] tlslv1_a_opcode, tlslv1_a_param, tlslv1_a_source;
  logic [7:0] tlslv1_a_size; logic [31:0] tlslv1_a_address; logic [15:0] tlslv1_a_mask;
  logic [127:0] tlslv1_a_data; logic tlslv1_a_corrupt, tlslv1_a_valid, tlslv1_a_ready;
  logic [2:0] tlslv1_d_opcode, tlslv1_d_source, tlslv1_d_sink; logic [1:0] tlslv1_d_param;
  logic [7:0] tlslv1_d_size; logic tlslv1_d_denied, tlslv1_d_corrupt, tlslv1_d_valid, tlslv1_d_ready;
  logic [127:0] tlslv1_d_data;

  logic [2:0] tlmst_a_opcode, tlmst_a_param, tlmst_a_source;
  logic [7:0] tlmst_a_size; logic [31:0] tlmst_a_address; logic [15:0] tlmst_a_mask;
  logic [127:0] tlmst_a_data; logic tlmst_a_corrupt, tlmst_a_valid, tlmst_a_ready;
  logic [2:0] tlmst_d_opcode, tlmst_d_source, tlmst_d_sink; logic [1:0] tlmst_d_param;
  logic [7:0] tlmst_d_size; logic tlmst_d_denied, tlmst_d_corrupt, tlmst_d_valid, tlmst_d_ready;
  logic [127:0] tlmst_d_data;

  // Outputs of the fixed-priority instance
  logic f_tlslv0_a_ready, f_tlslv1_a_ready, f_tlslv0_d_valid, f_tlslv1_d_valid;
  logic [2:0] f_tlslv0_d_opcode, f_tlslv0_d_source, f_tlslv0_d_sink, f_tlslv1_d_opcode, f_tlslv1_d_source, f_tlslv1_d_sink;
  logic [1:0] f_tlslv0_d_param, f_tlslv1_d_param; logic [7:0] f_tlslv0_d_size, f_tlslv1_d_size;
  logic f_tlslv0_d_denied, f_tlslv0_d_corrupt, f_tlslv1_d_denied, f_tlslv1_d_corrupt;
  logic [127:0] f_tlslv0_d_data, f_tlslv1_d_data;
  logic [2:0] f_tlmst_a_opcode, f_tlmst_a_param, f_tlmst_a_source; logic [7:0] f_tlmst_a_size;
  logic [31:0] f_tlmst_a_address; logic [15:0] f_tlmst_a_mask; logic [127:0] f_tlmst_a_data;
  logic f_tlmst_a_corrupt, f_tlmst_a_valid, f_tlmst_d_ready;

  tl_mem_arb #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .tlslv0_a_opcode(tlslv0_a_opcode), .tlslv0_a_param(tlslv0_a_param), .tlslv0_a_size(tlslv0_a_size),
    .tlslv0_a_source(tlslv0_a_source), .tlslv0_a_address(tlslv0_a_address), .tlslv0_a_mask(tlslv0_a_mask),
    .tlslv0_a_data(tlslv0_a_data), .tlslv0_a_corrupt(tlslv0_a_corrupt), .tlslv0_a_valid(tlslv0_a_valid),
    .tlslv0_a_ready(tlslv0_a_ready), .tlslv0_d_opcode(tlslv0_d_opcode), .tlslv0_d_param(tlslv0_d_param),
    .tlslv0_d_size(tlslv0_d_size), .tlslv0_d_source(tlslv0_d_source), .tlslv0_d_sink(tlslv0_d_sink),
    .tlslv0_d_denied(tlslv0_d_denied), .tlslv0_d_data(tlslv0_d_data), .tlslv0_d_corrupt(tlslv0_d_corrupt),
    .tlslv0_d_valid(tlslv0_d_valid), .tlslv0_d_ready(tlslv0_d_ready),
    .tlslv1_a_opcode(tlslv1_a_opcode), .tlslv1_a_param(tlslv1_a_param), .tlslv1_a_size(tlslv1_a_size),
    .tlslv1_a_source(tlslv1_a_source), .tlslv1_a_address(tlslv1_a_address), .tlslv1_a_mask(tlslv1_a_mask),
    .tlslv1_a_data(tlslv1_a_data), .tlslv1_a_corrupt(tlslv1_a_corrupt), .tlslv1_a_valid(tlslv1_a_valid),
    .tlslv1_a_ready(tlslv1_a_ready), .tlslv1_d_opcode(tlslv1_d_opcode), .tlslv1_d_param(tlslv1_d_param),
    .tlslv1_d_size(tlslv1_d_size), .tlslv1_d_source(tlslv1_d_source), .tlslv1_d_sink(tlslv1_d_sink),
    .tlslv1_d_denied(tlslv1_d_denied), .tlslv1_d_data(tlslv1_d_data), .tlslv1_d_corrupt(tlslv1_d_corrupt),
    .tlslv1_d_valid(tlslv1_d_valid), .tlslv1_d_ready(tlslv1_d_ready),
    .tlmst_a_opcode(tlmst_a_opcode), .tlmst_a_param(tlmst_a_param), .tlmst_a_size(tlmst_a_size),
    .tlmst_a_source(tlmst_a_source), .tlmst_a_address(tlmst_a_address), .tlmst_a_mask(tlmst_a_mask),
    .tlmst_a_data(tlmst_a_data), .tlmst_a_corrupt(tlmst_a_corrupt), .tlmst_a_valid(tlmst_a_valid),
    .tlmst_a_ready(tlmst_a_ready), .tlmst_d_opcode(tlmst_d_opcode), .tlmst_d_param(tlmst_d_param),
    .tlmst_d_size(tlmst_d_size), .tlmst_d_source(tlmst_d_source), .tlmst_d_sink(tlmst_d_sink),
    .tlmst_d_denied(tlmst_d_denied), .tlmst_d_data(tlmst_d_data), .tlmst_d_corrupt(tlmst_d_corrupt),
    .tlmst_d_valid(tlmst_d_valid), .tlmst_d_ready(tlmst_d_ready)
  );

  tl_mem_arb #(.RR_EN(0)) dut_fixed (
    .clk(clk), .rst(rst),
    .tlslv0_a_opcode(tlslv0_a_opcode), .tlslv0_a_param(tlslv0_a_param), .tlslv0_a_size(tlslv0_a_size),
    .tlslv0_a_source(tlslv0_a_source), .tlslv0_a_address(tlslv0_a_address), .tlslv0_a_mask(tlslv0_a_mask),
    .tlslv0_a_data(tlslv0_a_data), .tlslv0_a_corrupt(tlslv0_a_corrupt), .tlslv0_a_valid(tlslv0_a_valid),
    .tlslv0_a_ready(f_tlslv0_a_ready), .tlslv0_d_opcode(f_tlslv0_d_opcode), .tlslv0_d_param(f_tlslv0_d_param),
    .tlslv0_d_size(f_tlslv0_d_size), .tlslv0_d_source(f_tlslv0_d_source), .tlslv0_d_sink(f_tlslv0_d_sink),
    .tlslv0_d_denied(f_tlslv0_d_denied), .tlslv0_d_data(f_tlslv0_d_data), .tlslv0_d_corrupt(f_tlslv0_d_corrupt),
    .tlslv0_d_valid(f_tlslv0_d_valid), .tlslv0_d_ready(tlslv0_d_ready),
    .tlslv1_a_opcode(tlslv1_a_opcode), .tlslv1_a_param(tlslv1_a_param), .tlslv1_a_size(tlslv1_a_size),
    .tlslv1_a_source(tlslv1_a_source), .tlslv1_a_address(tlslv1_a_address), .tlslv1_a_mask(tlslv1_a_mask),
    .tlslv1_a_data(tlslv1_a_data), .tlslv1_a_corrupt(tlslv1_a_corrupt), .tlslv1_a_valid(tlslv1_a_valid),
    .tlslv1_a_ready(f_tlslv1_a_ready), .tlslv1_d_opcode(f_tlslv1_d_opcode), .tlslv1_d_param(f_tlslv1_d_param),
    .tlslv1_d_size(f_tlslv1_d_size), .tlslv1_d_source(f_tlslv1_d_source), .tlslv1_d_sink(f_tlslv1_d_sink),
    .tlslv1_d_denied(f_tlslv1_d_denied), .tlslv1_d_data(f_tlslv1_d_data), .tlslv1_d_corrupt(f_tlslv1_d_corrupt),
    .tlslv1_d_valid(f_tlslv1_d_valid), .tlslv1_d_ready(tlslv1_d_ready),
    .tlmst_a_opcode(f_tlmst_a_opcode), .tlmst_a_param(f_tlmst_a_param), .tlmst_a_size(f_tlmst_a_size),
    .tlmst_a_source(f_tlmst_a_source), .tlmst_a_address(f_tlmst_a_address), .tlmst_a_mask(f_tlmst_a_mask),
    .tlmst_a_data(f_tlmst_a_data), .tlmst_a_corrupt(f_tlmst_a_corrupt), .tlmst_a_valid(f_tlmst_a_valid),
    .tlmst_a_ready(tlmst_a_ready), .tlmst_d_opcode(tlmst_d_opcode), .tlmst_d_param(tlmst_d_param),
    .tlmst_d_size(tlmst_d_size), .tlmst_d_source(tlmst_d_source), .tlmst_d_sink(tlmst_d_sink),
    .tlmst_d_denied(tlmst_d_denied), .tlmst_d_data(tlmst_d_data), .tlmst_d_corrupt(tlmst_d_corrupt),
    .tlmst_d_valid(tlmst_d_valid), .tlmst_d_ready(f_tlmst_d_ready)
  );

  // The memory model follows whichever instance is selected.
  logic use_f;
  logic m_a_valid, m_d_ready;
  logic [2:0] m_a_opcode, m_a_source; logic [7:0] m_a_size; logic [31:0] m_a_address; logic [127:0] m_a_data;
  assign m_a_valid   = use_f ? f_tlmst_a_valid   : tlmst_a_valid;
  assign m_d_ready   = use_f ? f_tlmst_d_ready   : tlmst_d_ready;
  assign m_a_opcode  = use_f ? f_tlmst_a_opcode  : tlmst_a_opcode;
  assign m_a_source  = use_f ? f_tlmst_a_source  : tlmst_a_source;
  assign m_a_size    = use_f ? f_tlmst_a_size    : tlmst_a_size;
  assign m_a_address = use_f ? f_tlmst_a_address : tlmst_a_address;
  assign m_a_data    = use_f ? f_tlmst_a_data    : tlmst_a_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nb(input logic [7:0] s);
    return (s <= 8'd4) ? 1 : (1 << (s - 8'd4));
  endfunction

  logic [127:0] mem [0:15];

  // tl_mem model: outputs change at negedge, handshakes are judged just before posedge.
  initial begin
    int d_rem, a_rem, d_idx, w_idx;
    logic [2:0] rop, rsrc; logic [7:0] rsz; logic [3:0] ridx;
    d_rem = 0; a_rem = 0; d_idx = 0; w_idx = 0; rop = '0; rsrc = '0; rsz = '0; ridx = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tlmst_a_ready = 1'b1; tlmst_d_valid = 1'b0; tlmst_d_opcode = '0; tlmst_d_param = '0;
    tlmst_d_size = '0; tlmst_d_source = '0; tlmst_d_sink = '0; tlmst_d_denied = 1'b0;
    tlmst_d_data = '0; tlmst_d_corrupt = 1'b0;
    forever begin
      @(negedge clk);
      tlmst_a_ready  = (d_rem == 0);
      tlmst_d_valid  = (d_rem > 0);
      tlmst_d_opcode = (rop == 3'd4) ? 3'd1 : 3'd0;
      tlmst_d_data   = (rop == 3'd4) ? mem[4'(ridx + d_idx)] : '0;
      tlmst_d_size   = rsz;
      tlmst_d_source = rsrc;
      #2;
      if (rst) begin
        d_rem = 0; a_rem = 0;
      end else begin
        if (tlmst_d_valid && m_d_ready) begin d_rem--; d_idx++; end
        if (m_a_valid && tlmst_a_ready) begin
          if (a_rem == 0) begin
            rop = m_a_opcode; rsz = m_a_size; rsrc = m_a_source; ridx = m_a_address[7:4];
            d_idx = 0; w_idx = 1;
            if (rop == 3'd0 || rop == 3'd1) begin
              mem[ridx] = m_a_data;
              a_rem = nb(rsz) - 1;
              if (a_rem == 0) d_rem = 1;
            end else d_rem = nb(rsz);
          end else begin
            mem[4'(ridx + w_idx)] = m_a_data; w_idx++; a_rem--;
            if (a_rem == 0) d_rem = 1;
          end
        end
      end
    end
  end

  task automatic drive_a0(input logic v, input logic [2:0] op, input logic [7:0] sz,
                          input logic [2:0] src, input logic [31:0] addr, input logic [127:0] dat);
    tlslv0_a_valid = v; tlslv0_a_opcode = op; tlslv0_a_size = sz;
    tlslv0_a_source = src; tlslv0_a_address = addr; tlslv0_a_data = dat;
  endtask

  task automatic drive_a1(input logic v, input logic [2:0] op, input logic [7:0] sz,
                          input logic [2:0] src, input logic [31:0] addr, input logic [127:0] dat);
    tlslv1_a_valid = v; tlslv1_a_opcode = op; tlslv1_a_size = sz;
    tlslv1_a_source = src; tlslv1_a_address = addr; tlslv1_a_data = dat;
  endtask

  task automatic idle_inputs();
    tlslv0_a_valid = 1'b0; tlslv1_a_valid = 1'b0; tlslv0_d_ready = 1'b1; tlslv1_d_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle_inputs();
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    drive_a0(1'b1, 3'd0, 8'd5, 3'd2, 32'h0, 128'h1); drive_a1(1'b1, 3'd4, 8'd4, 3'd5, 32'h0, 128'h0); #1;
    tests++; if (tlmst_a_valid !== 1'b0) begin fails++; $display("FAIL rst_a_valid: got %0b exp 0", tlmst_a_valid); end
    tests++; if (tlslv0_a_ready !== 1'b0) begin fails++; $display("FAIL rst_a_ready0: got %0b exp 0", tlslv0_a_ready); end
    tests++; if (tlslv1_a_ready !== 1'b0) begin fails++; $display("FAIL rst_a_ready1: got %0b exp 0", tlslv1_a_ready); end
    tests++; if (tlmst_d_ready !== 1'b0) begin fails++; $display("FAIL rst_d_ready: got %0b exp 0", tlmst_d_ready); end
    tests++; if ({tlslv0_d_valid, tlslv1_d_valid} !== 2'b00) begin fails++; $display("FAIL rst_d_valid: got %b exp 00", {tlslv0_d_valid, tlslv1_d_valid}); end
    @(negedge clk); idle_inputs();
    @(negedge clk); rst = 1'b0; #1;
    tests++; if (tlmst_a_valid !== 1'b0) begin fails++; $display("FAIL rst_idle_a_valid: got %0b exp 0", tlmst_a_valid); end
  endtask

  task automatic test_put_single();
    @(negedge clk); drive_a0(1'b1, 3'd0, 8'd5, 3'd2, 32'h0, 128'h1); #1;
    tests++; if (tlmst_a_valid !== 1'b1 || tlmst_a_data !== 128'h1) begin fails++; $display("FAIL put_beat0: valid %0b data %0h exp 1/1", tlmst_a_valid, tlmst_a_data); end
    tests++; if (tlslv0_a_ready !== 1'b1) begin fails++; $display("FAIL put_ready0: got %0b exp 1", tlslv0_a_ready); end
    @(negedge clk); drive_a0(1'b1, 3'd0, 8'd5, 3'd2, 32'h0, 128'h2); #1;
    tests++; if (tlmst_a_valid !== 1'b1 || tlmst_a_data !== 128'h2) begin fails++; $display("FAIL put_beat1: valid %0b data %0h exp 1/2", tlmst_a_valid, tlmst_a_data); end
    tests++; if (tlslv1_d_valid !== 1'b0) begin fails++; $display("FAIL put_d1_a: got %0b exp 0", tlslv1_d_valid); end
    @(negedge clk); tlslv0_a_valid = 1'b0; #1;
    tests++; if (tlslv0_d_valid !== 1'b1 || tlslv0_d_opcode !== 3'd0) begin fails++; $display("FAIL put_ack: valid %0b op %0d exp 1/0", tlslv0_d_valid, tlslv0_d_opcode); end
    tests++; if (tlslv1_d_valid !== 1'b0) begin fails++; $display("FAIL put_d1_b: got %0b exp 0", tlslv1_d_valid); end
    @(negedge clk); #1;
    tests++; if (tlslv0_d_valid !== 1'b0 || tlslv1_d_valid !== 1'b0) begin fails++; $display("FAIL put_done: d_valid %0b%0b exp 00", tlslv0_d_valid, tlslv1_d_valid); end
  endtask

  task automatic test_both_get();
    do_reset();
    @(negedge clk); drive_a0(1'b1, 3'd4, 8'd5, 3'd2, 32'h0, 128'h0); drive_a1(1'b1, 3'd4, 8'd5, 3'd5, 32'h0, 128'h0); #1;
    tests++; if (tlslv0_a_ready !== 1'b1 || tlslv1_a_ready !== 1'b0) begin fails++; $display("FAIL get_first_gnt: ready %0b%0b exp 10", tlslv0_a_ready, tlslv1_a_ready); end
    tests++; if (tlmst_a_source !== 3'd2) begin fails++; $display("FAIL get_first_src: got %0d exp 2", tlmst_a_source); end
    @(negedge clk); tlslv0_a_valid = 1'b0; #1;
    tests++; if (tlslv0_d_valid !== 1'b1 || tlslv0_d_opcode !== 3'd1 || tlslv0_d_data !== 128'h1) begin fails++; $display("FAIL get_beat0: v %0b op %0d data %0h exp 1/1/1", tlslv0_d_valid, tlslv0_d_opcode, tlslv0_d_data); end
    tests++; if (tlslv1_a_ready !== 1'b0 || tlmst_a_valid !== 1'b0) begin fails++; $display("FAIL get_lock: ready1 %0b a_valid %0b exp 0/0", tlslv1_a_ready, tlmst_a_valid); end
    @(negedge clk); #1;
    tests++; if (tlslv0_d_valid !== 1'b1 || tlslv0_d_data !== 128'h2) begin fails++; $display("FAIL get_beat1: v %0b data %0h exp 1/2", tlslv0_d_valid, tlslv0_d_data); end
    tests++; if (tlslv1_a_ready !== 1'b0) begin fails++; $display("FAIL get_last_d_no_gnt: got %0b exp 0", tlslv1_a_ready); end
    @(negedge clk); #1;
    tests++; if (tlslv1_a_ready !== 1'b1 || tlmst_a_source !== 3'd5) begin fails++; $display("FAIL get_second_gnt: ready %0b src %0d exp 1/5", tlslv1_a_ready, tlmst_a_source); end
    @(negedge clk); tlslv1_a_valid = 1'b0; #1;
    tests++; if (tlslv1_d_valid !== 1'b1 || tlslv0_d_valid !== 1'b0 || tlslv1_d_data !== 128'h1) begin fails++; $display("FAIL get_r1_beat0: v1 %0b v0 %0b data %0h exp 1/0/1", tlslv1_d_valid, tlslv0_d_valid, tlslv1_d_data); end
    @(negedge clk); #1;
    tests++; if (tlslv1_d_valid !== 1'b1 || tlslv1_d_data !== 128'h2) begin fails++; $display("FAIL get_r1_beat1: v %0b data %0h exp 1/2", tlslv1_d_valid, tlslv1_d_data); end
    @(negedge clk);
  endtask

  task automatic test_burst_lock();
    do_reset();
    @(negedge clk); drive_a0(1'b1, 3'd0, 8'd5, 3'd2, 32'h0, 128'hA); drive_a1(1'b1, 3'd4, 8'd4, 3'd5, 32'h0, 128'h0); #1;
    tests++; if (tlslv0_a_ready !== 1'b1 || tlslv1_a_ready !== 1'b0) begin fails++; $display("FAIL lock_gnt: ready %0b%0b exp 10", tlslv0_a_ready, tlslv1_a_ready); end
    @(negedge clk); tlslv0_a_valid = 1'b0; #1;
    tests++; if (tlslv1_a_ready !== 1'b0 || tlmst_a_valid !== 1'b0) begin fails++; $display("FAIL lock_gap: ready1 %0b a_valid %0b exp 0/0", tlslv1_a_ready, tlmst_a_valid); end
    @(negedge clk); drive_a0(1'b1, 3'd0, 8'd5, 3'd2, 32'h0, 128'hB); #1;
    tests++; if (tlslv0_a_ready !== 1'b1 || tlslv1_a_ready !== 1'b0 || tlmst_a_data !== 128'hB) begin fails++; $display("FAIL lock_beat1: ready %0b%0b data %0h exp 10/b", tlslv0_a_ready, tlslv1_a_ready, tlmst_a_data); end
    @(negedge clk); tlslv0_a_valid = 1'b0; #1;
    tests++; if (tlslv0_d_valid !== 1'b1 || tlslv1_a_ready !== 1'b0) begin fails++; $display("FAIL lock_ack: d_valid0 %0b ready1 %0b exp 1/0", tlslv0_d_valid, tlslv1_a_ready); end
    @(negedge clk); #1;
    tests++; if (tlslv1_a_ready !== 1'b1) begin fails++; $display("FAIL lock_release: got %0b exp 1", tlslv1_a_ready); end
    @(negedge clk); tlslv1_a_valid = 1'b0; #1;
    tests++; if (tlslv1_d_valid !== 1'b1 || tlslv1_d_data !== 128'hA) begin fails++; $display("FAIL lock_r1_data: v %0b data %0h exp 1/a", tlslv1_d_valid, tlslv1_d_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [127:0] got [0:3];
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) got[k] = '0;
    do_reset();
    @(negedge clk); drive_a0(1'b1, 3'd4, 8'd5, 3'd2, 32'h0, 128'h0); #1;
    tests++; if (tlslv0_a_ready !== 1'b1) begin fails++; $display("FAIL bp_gnt: got %0b exp 1", tlslv0_a_ready); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); tlslv0_a_valid = 1'b0; tlslv0_d_ready = (i >= 3); #1;
      if (i < 3) begin
        tests++; if (tlmst_d_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low%0d: got %0b exp 0", i, tlmst_d_ready); end
        tests++; if (tlslv0_d_valid !== 1'b1 || tlslv0_d_data !== 128'hA) begin fails++; $display("FAIL bp_hold%0d: v %0b data %0h exp 1/a", i, tlslv0_d_valid, tlslv0_d_data); end
      end
      if (tlslv0_d_valid && tlslv0_d_ready) begin
        if (n < 4) got[n] = tlslv0_d_data;
        n++;
      end
    end
    tests++; if (n !== 2) begin fails++; $display("FAIL bp_count: got %0d exp 2", n); end
    tests++; if (got[0] !== 128'hA || got[1] !== 128'hB) begin fails++; $display("FAIL bp_order: got %0h,%0h exp a,b", got[0], got[1]); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    @(negedge clk); drive_a0(1'b1, 3'd0, 8'd5, 3'd2, 32'h0, 128'h55); #1;
    tests++; if (tlslv0_a_ready !== 1'b1) begin fails++; $display("FAIL mid_beat0: got %0b exp 1", tlslv0_a_ready); end
    @(negedge clk); rst = 1'b1; drive_a0(1'b1, 3'd0, 8'd5, 3'd2, 32'h0, 128'h66); #1;
    tests++; if ({tlmst_a_valid, tlslv0_a_ready, tlslv1_a_ready, tlmst_d_ready, tlslv0_d_valid, tlslv1_d_valid} !== 6'b0)
      begin fails++; $display("FAIL mid_quiesce: got %b exp 000000", {tlmst_a_valid, tlslv0_a_ready, tlslv1_a_ready, tlmst_d_ready, tlslv0_d_valid, tlslv1_d_valid}); end
    @(negedge clk); rst = 1'b0; tlslv0_a_valid = 1'b0; drive_a1(1'b1, 3'd4, 8'd4, 3'd5, 32'h0, 128'h0); #1;
    tests++; if (tlslv1_a_ready !== 1'b1 || tlslv0_a_ready !== 1'b0 || tlmst_a_source !== 3'd5) begin fails++; $display("FAIL mid_regrant: ready %0b%0b src %0d exp 01/5", tlslv0_a_ready, tlslv1_a_ready, tlmst_a_source); end
    @(negedge clk); tlslv1_a_valid = 1'b0; #1;
    tests++; if (tlslv1_d_valid !== 1'b1 || tlslv1_d_opcode !== 3'd1 || tlslv1_d_data !== 128'h55) begin fails++; $display("FAIL mid_r1_data: v %0b op %0d data %0h exp 1/1/55", tlslv1_d_valid, tlslv1_d_opcode, tlslv1_d_data); end
    @(negedge clk); #1;
    tests++; if (tlslv1_d_valid !== 1'b0) begin fails++; $display("FAIL mid_done: got %0b exp 0", tlslv1_d_valid); end
  endtask

  task automatic test_fixed_priority();
    use_f = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_a0(1'b1, 3'd0, 8'd4, 3'd2, 32'h20, 128'(k + 16)); drive_a1(1'b1, 3'd0, 8'd4, 3'd5, 32'h30, 128'h77); #1;
      tests++; if (f_tlslv0_a_ready !== 1'b1 || f_tlslv1_a_ready !== 1'b0) begin fails++; $display("FAIL fp_gnt%0d: ready %0b%0b exp 10", k, f_tlslv0_a_ready, f_tlslv1_a_ready); end
      @(negedge clk); #1;
      tests++; if (f_tlslv0_d_valid !== 1'b1 || f_tlslv1_a_ready !== 1'b0) begin fails++; $display("FAIL fp_ack%0d: d_valid0 %0b ready1 %0b exp 1/0", k, f_tlslv0_d_valid, f_tlslv1_a_ready); end
    end
    @(negedge clk); tlslv0_a_valid = 1'b0; #1;
    tests++; if (f_tlslv1_a_ready !== 1'b1 || f_tlmst_a_source !== 3'd5) begin fails++; $display("FAIL fp_r1_gnt: ready %0b src %0d exp 1/5", f_tlslv1_a_ready, f_tlmst_a_source); end
    @(negedge clk); tlslv1_a_valid = 1'b0; #1;
    tests++; if (f_tlslv1_d_valid !== 1'b1 || f_tlslv0_d_valid !== 1'b0) begin fails++; $display("FAIL fp_r1_ack: v1 %0b v0 %0b exp 1/0", f_tlslv1_d_valid, f_tlslv0_d_valid); end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; fails = 0; use_f = 1'b0; rst = 1'b1;
    tlslv0_a_param = '0; tlslv0_a_mask = '1; tlslv0_a_corrupt = 1'b0;
    tlslv1_a_param = '0; tlslv1_a_mask = '1; tlslv1_a_corrupt = 1'b0;
    drive_a0(1'b0, 3'd0, 8'd0, 3'd0, 32'h0, 128'h0);
    drive_a1(1'b0, 3'd0, 8'd0, 3'd0, 32'h0, 128'h0);
    idle_inputs();
    test_reset();
    test_put_single();
    test_both_get();
    test_burst_lock();
    test_backpressure();
    test_reset_mid_burst();
    test_fixed_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
